// File: rtl/reg_file_sb.sv
// Integer register file with write-through bypass and a pending-write scoreboard.
// x0 is not stored: it always reads zero and is never busy.
module reg_file_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic [4:0]      reg_write_addr,
    input  logic [XLEN-1:0] reg_write_data,
    input  logic            reg_write_enable,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            flush,
    output logic [4:0]      busy_count
);

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            wr_act;
    logic [4:0]      busy_cnt;

    assign wr_act = reg_write_enable && (reg_write_addr != 5'd0);

    // Issue is applied after write-back so a same-cycle issue to the same rd stays busy.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wr_act) begin
                busy_d[reg_write_addr] = 1'b0;
            end
            if (issue_valid && (issue_rd != 5'd0)) begin
                busy_d[issue_rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            if (wr_act) begin
                regs_q[reg_write_addr] <= reg_write_data;
            end
        end
    end

    always_comb begin
        rs1_data = '0;
        if (rs1_addr != 5'd0) begin
            if (wr_act && (reg_write_addr == rs1_addr)) begin
                rs1_data = reg_write_data;
            end else begin
                rs1_data = regs_q[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != 5'd0) begin
            if (wr_act && (reg_write_addr == rs2_addr)) begin
                rs2_data = reg_write_data;
            end else begin
                rs2_data = regs_q[rs2_addr];
            end
        end
    end

    // busy_q[0] is held at zero, so address 0 never reports a hazard.
    assign rs1_busy = busy_q[rs1_addr] & ~(wr_act && (reg_write_addr == rs1_addr));
    assign rs2_busy = busy_q[rs2_addr] & ~(wr_act && (reg_write_addr == rs2_addr));

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_cnt = busy_cnt + {4'd0, busy_q[i]};
        end
    end

    assign busy_count = busy_cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios followed by random
// traffic, all compared against an array-based reference model.
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;
    logic        reg_write_enable;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [4:0]  busy_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    reg_file_sb #(.XLEN(32), .NREG(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .rs1_busy         (rs1_busy),
        .rs2_busy         (rs2_busy),
        .reg_write_addr   (reg_write_addr),
        .reg_write_data   (reg_write_data),
        .reg_write_enable (reg_write_enable),
        .issue_valid      (issue_valid),
        .issue_rd         (issue_rd),
        .flush            (flush),
        .busy_count       (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit wr_hits(input logic [4:0] a);
        return reg_write_enable && (reg_write_addr != 0) && (reg_write_addr == a);
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wr_hits(a)) return reg_write_data;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a);
        return {31'd0, (a != 0) && m_busy[a] && !wr_hits(a)};
    endfunction

    function automatic logic [31:0] exp_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return 32'(c);
    endfunction

    // Checks the current cycle against the model, then advances one clock.
    task automatic step(input bit chk = 1'b1);
        #1;
        if (chk) begin
            check("rs1_data", rs1_data, exp_data(rs1_addr));
            check("rs2_data", rs2_data, exp_data(rs2_addr));
            check("rs1_busy", {31'd0, rs1_busy}, exp_busy(rs1_addr));
            check("rs2_busy", {31'd0, rs2_busy}, exp_busy(rs2_addr));
            check("busy_count", {27'd0, busy_count}, exp_count());
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (reg_write_enable && reg_write_addr != 0) m_regs[reg_write_addr] = reg_write_data;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else begin
                if (reg_write_enable && reg_write_addr != 0) m_busy[reg_write_addr] = 1'b0;
                if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rs1_addr = '0; rs2_addr = '0;
        reg_write_addr = '0; reg_write_data = '0; reg_write_enable = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0);
        rst = 1'b0;

        // Reset clears written data
        reg_write_enable = 1'b1; reg_write_addr = 5'd5; reg_write_data = 32'hDEADBEEF;
        step();
        reg_write_enable = 1'b0; rs1_addr = 5'd5;
        #1 check("x5 before reset", rs1_data, 32'hDEADBEEF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("x5 after reset", rs1_data, 32'h0);
        check("rs1_busy after reset", {31'd0, rs1_busy}, 32'h0);
        check("busy_count after reset", {27'd0, busy_count}, 32'h0);
        step();

        // Write/read and x0
        reg_write_enable = 1'b1; reg_write_addr = 5'd7; reg_write_data = 32'h12345678;
        step();
        reg_write_addr = 5'd0; reg_write_data = 32'hFFFFFFFF;
        step();
        reg_write_enable = 1'b0; rs1_addr = 5'd7; rs2_addr = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        check("x7 read", rs1_data, 32'h12345678);
        check("x0 read", rs2_data, 32'h0);
        step();
        issue_valid = 1'b0;
        #1 check("issue x0 count", {27'd0, busy_count}, 32'h0);

        // Same-cycle bypass
        rs1_addr = 5'd9; rs2_addr = 5'd9;
        #1 check("x9 stored before", rs1_data, 32'h0);
        reg_write_enable = 1'b1; reg_write_addr = 5'd9; reg_write_data = 32'hA5A5A5A5;
        #1;
        check("bypass rs1", rs1_data, 32'hA5A5A5A5);
        check("bypass rs2", rs2_data, 32'hA5A5A5A5);
        step();
        reg_write_enable = 1'b0;

        // Scoreboard set and clear
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        issue_valid = 1'b0; rs1_addr = 5'd3;
        #1;
        check("x3 busy after issue", {31'd0, rs1_busy}, 32'h1);
        check("count after issue", {27'd0, busy_count}, 32'h1);
        step();
        step();
        step();
        reg_write_enable = 1'b1; reg_write_addr = 5'd3; reg_write_data = 32'h55;
        #1;
        check("x3 busy at wb", {31'd0, rs1_busy}, 32'h0);
        check("x3 data at wb", rs1_data, 32'h55);
        step();
        reg_write_enable = 1'b0;
        #1 check("count after wb", {27'd0, busy_count}, 32'h0);

        // Simultaneous issue and write-back to the same rd
        issue_valid = 1'b1; issue_rd = 5'd4;
        step();
        reg_write_enable = 1'b1; reg_write_addr = 5'd4; reg_write_data = 32'h11;
        step();
        issue_valid = 1'b0; reg_write_enable = 1'b0; rs1_addr = 5'd4;
        #1;
        check("x4 still busy", {31'd0, rs1_busy}, 32'h1);
        check("count with x4", {27'd0, busy_count}, 32'h1);
        check("x4 data", rs1_data, 32'h11);
        reg_write_enable = 1'b1;
        step();
        reg_write_enable = 1'b0;

        // Flush drops concurrent issue but commits write-back
        issue_valid = 1'b1; issue_rd = 5'd1;
        step();
        issue_rd = 5'd2;
        step();
        issue_rd = 5'd3;
        step();
        issue_valid = 1'b0;
        #1 check("count before flush", {27'd0, busy_count}, 32'h3);
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd6;
        reg_write_enable = 1'b1; reg_write_addr = 5'd2; reg_write_data = 32'h77;
        step();
        flush = 1'b0; issue_valid = 1'b0; reg_write_enable = 1'b0;
        rs1_addr = 5'd6; rs2_addr = 5'd2;
        #1;
        check("count after flush", {27'd0, busy_count}, 32'h0);
        check("x6 not busy", {31'd0, rs1_busy}, 32'h0);
        check("x2 after flush", rs2_data, 32'h77);
        step();

        // Reset mid-operation drops pending busy bits
        issue_valid = 1'b1; issue_rd = 5'd10;
        step();
        issue_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        #1 check("count after mid reset", {27'd0, busy_count}, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst              = ($urandom_range(0, 99) == 0);
            flush            = ($urandom_range(0, 15) == 0);
            issue_valid      = $urandom_range(0, 1);
            issue_rd         = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            reg_write_enable = $urandom_range(0, 1);
            reg_write_addr   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            reg_write_data   = $urandom;
            rs1_addr         = ($urandom_range(0, 2) == 0) ? reg_write_addr : 5'($urandom);
            rs2_addr         = ($urandom_range(0, 2) == 0) ? issue_rd : 5'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
